// File: rtl/dmem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the shared data-memory port.
// Handshake: a requester holds *_req (and its payload) until the one-cycle *_resp pulse
// (loads may also drop on flush); the arbiter holds mem_read/mem_write and the latched
// address/data/byte enables stable until the memory returns the one-cycle mem_resp.
interface dmem_port_arbiter_if;
  logic        flush;
  logic        st_req;
  logic [15:0] st_addr;
  logic [15:0] st_wdata;
  logic [1:0]  st_byte_en;
  logic        st_resp;
  logic        ld_req;
  logic [15:0] ld_addr;
  logic        ld_resp;
  logic [15:0] ld_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic        mem_resp;
  logic [15:0] mem_rdata;

  modport master (
    input  flush, st_req, st_addr, st_wdata, st_byte_en, ld_req, ld_addr, mem_resp, mem_rdata,
    output st_resp, ld_resp, ld_rdata, mem_read, mem_write, mem_address, mem_wdata,
           mem_byte_enable
  );

  modport slave (
    output flush, st_req, st_addr, st_wdata, st_byte_en, ld_req, ld_addr, mem_resp, mem_rdata,
    input  st_resp, ld_resp, ld_rdata, mem_read, mem_write, mem_address, mem_wdata,
           mem_byte_enable
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between commit stores (priority) and speculative loads,
// with a load-starvation limit. Optional perf counters under `DMEM_ARB_PERF_EN`.
module dmem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_WIDTH    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_port_arbiter_if.master  bus,
  output logic [1:0]           dbg_state,
  output logic [CNT_WIDTH-1:0] dbg_starve_cnt
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]          perf_st_grants,
  output logic [31:0]          perf_ld_grants,
  output logic [31:0]          perf_ld_killed
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STORE = 2'd1,
    LOAD  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

  state_t               state;
  logic [CNT_WIDTH-1:0] starve_cnt;
  logic                 kill;
  logic [15:0]          addr_q;
  logic [15:0]          wdata_q;
  logic [1:0]           be_q;

  logic ld_live;
  logic st_grant;
  logic ld_grant;
  logic ld_drop;

  // A load seen together with flush is already stale: it neither competes nor starves.
  assign ld_live  = bus.ld_req & ~bus.flush;
  assign st_grant = (state == IDLE) & bus.st_req & (~ld_live | (starve_cnt < LIMIT));
  assign ld_grant = (state == IDLE) & ~st_grant & ld_live;
  assign ld_drop  = (state == LOAD) & bus.mem_resp & (kill | bus.flush);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      kill       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= 2'b11;
    end else begin
      case (state)
        IDLE: begin
          if (st_grant) begin
            state   <= STORE;
            addr_q  <= bus.st_addr;
            wdata_q <= bus.st_wdata;
            be_q    <= bus.st_byte_en;
            if (ld_live && (starve_cnt != '1)) starve_cnt <= starve_cnt + CNT_WIDTH'(1);
          end else if (ld_grant) begin
            state      <= LOAD;
            addr_q     <= bus.ld_addr;
            be_q       <= 2'b11;
            starve_cnt <= '0;
          end
        end
        STORE: begin
          if (bus.mem_resp) state <= IDLE;
        end
        LOAD: begin
          // The bus transaction always runs to mem_resp; flush only poisons the result.
          if (bus.mem_resp) begin
            state <= IDLE;
            kill  <= 1'b0;
          end else if (bus.flush) begin
            kill <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_write       = (state == STORE);
  assign bus.mem_read        = (state == LOAD);
  assign bus.mem_address     = addr_q;
  assign bus.mem_wdata       = wdata_q;
  assign bus.mem_byte_enable = (state == IDLE) ? 2'b11 : be_q;
  assign bus.st_resp         = (state == STORE) & bus.mem_resp;
  assign bus.ld_resp         = (state == LOAD) & bus.mem_resp & ~kill & ~bus.flush;
  assign bus.ld_rdata        = bus.ld_resp ? bus.mem_rdata : 16'h0000;

  assign dbg_state      = state;
  assign dbg_starve_cnt = starve_cnt;

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_st_grants <= '0;
      perf_ld_grants <= '0;
      perf_ld_killed <= '0;
    end else begin
      if (st_grant) perf_st_grants <= perf_st_grants + 32'd1;
      if (ld_grant) perf_ld_grants <= perf_ld_grants + 32'd1;
      if (ld_drop)  perf_ld_killed <= perf_ld_killed + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: a latency-programmable memory responder plus
// one task per scenario with hand-computed expectations.
module tb_dmem_port_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;
  logic [3:0] dbg_starve_cnt;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_st_grants, perf_ld_grants, perf_ld_killed;
`endif

  int          checks = 0;
  int          errors = 0;
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic [15:0] mem_data = 16'h0000;

  dmem_port_arbiter_if bus();

  dmem_port_arbiter #(.STARVE_LIMIT(4), .CNT_WIDTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .dbg_state      (dbg_state),
    .dbg_starve_cnt (dbg_starve_cnt)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_st_grants (perf_st_grants),
    .perf_ld_grants (perf_ld_grants),
    .perf_ld_killed (perf_ld_killed)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Memory model: mem_resp in the mem_lat-th cycle of a transaction
  initial begin
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      bus.mem_rdata = mem_data;
      if (bus.mem_read || bus.mem_write) begin
        mem_cnt      = mem_cnt + 1;
        bus.mem_resp = (mem_cnt == mem_lat);
      end else begin
        mem_cnt      = 0;
        bus.mem_resp = 1'b0;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.flush = 0; bus.st_req = 0; bus.st_addr = 0; bus.st_wdata = 0;
    bus.st_byte_en = 0; bus.ld_req = 0; bus.ld_addr = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) step();
    checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %0b expected 0", bus.mem_read); end
    checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %0b expected 0", bus.mem_write); end
    checks++; if (bus.mem_byte_enable !== 2'b11) begin errors++; $display("FAIL reset_byte_en: got %b expected 11", bus.mem_byte_enable); end
    checks++; if (bus.mem_address !== 16'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0000", bus.mem_address); end
    checks++; if (bus.st_resp !== 1'b0 || bus.ld_resp !== 1'b0) begin errors++; $display("FAIL reset_resp: got st=%0b ld=%0b expected 0 0", bus.st_resp, bus.ld_resp); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    checks++; if (dbg_starve_cnt !== 4'd0) begin errors++; $display("FAIL reset_starve: got %0d expected 0", dbg_starve_cnt); end
`ifdef DMEM_ARB_PERF_EN
    checks++; if ({perf_st_grants, perf_ld_grants, perf_ld_killed} !== 96'd0) begin errors++; $display("FAIL reset_perf: got %0d/%0d/%0d expected 0/0/0", perf_st_grants, perf_ld_grants, perf_ld_killed); end
`endif
    reset = 1'b0;
  endtask

  task automatic test_single_store();
    int wr = 0;
    int resp = 0;
    mem_lat = 3;
    bus.st_addr = 16'h0040; bus.st_wdata = 16'hBEEF; bus.st_byte_en = 2'b01; bus.st_req = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.mem_write) begin
        wr++;
        checks++; if (bus.mem_address !== 16'h0040 || bus.mem_wdata !== 16'hBEEF || bus.mem_byte_enable !== 2'b01) begin
          errors++; $display("FAIL store_payload: got %h/%h/%b expected 0040/beef/01", bus.mem_address, bus.mem_wdata, bus.mem_byte_enable);
        end
      end
      if (bus.st_resp) begin resp++; bus.st_req = 0; end
      // Requester payload wanders mid-transaction; the latched copy must not.
      if (i == 1) begin bus.st_addr = 16'hFFFF; bus.st_wdata = 16'h0000; bus.st_byte_en = 2'b10; end
    end
    checks++; if (wr != 3) begin errors++; $display("FAIL store_write_cycles: got %0d expected 3", wr); end
    checks++; if (resp != 1) begin errors++; $display("FAIL store_resp_count: got %0d expected 1", resp); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL store_end_state: got %0d expected 0", dbg_state); end
  endtask

  task automatic test_single_load();
    int rd = 0;
    int resp = 0;
    mem_lat = 2; mem_data = 16'h1234;
    bus.ld_addr = 16'h0100; bus.ld_req = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.mem_read) begin
        rd++;
        checks++; if (bus.mem_write !== 1'b0 || bus.mem_address !== 16'h0100 || bus.mem_byte_enable !== 2'b11) begin
          errors++; $display("FAIL load_bus: got wr=%0b addr=%h be=%b expected 0/0100/11", bus.mem_write, bus.mem_address, bus.mem_byte_enable);
        end
      end
      if (bus.ld_resp) begin
        resp++; bus.ld_req = 0;
        checks++; if (bus.ld_rdata !== 16'h1234) begin errors++; $display("FAIL load_rdata: got %h expected 1234", bus.ld_rdata); end
      end
    end
    checks++; if (rd != 2) begin errors++; $display("FAIL load_read_cycles: got %0d expected 2", rd); end
    checks++; if (resp != 1) begin errors++; $display("FAIL load_resp_count: got %0d expected 1", resp); end
  endtask

  task automatic test_starvation();
    int   stores = 0;
    logic prev_wr = 0;
    logic got_load = 0;
    logic got_resp = 0;
    mem_lat = 1; mem_data = 16'h2222;
    bus.st_addr = 16'h0010; bus.st_wdata = 16'h1111; bus.st_byte_en = 2'b11;
    bus.ld_addr = 16'h0020; bus.st_req = 1; bus.ld_req = 1;
    for (int i = 0; i < 40 && !got_resp; i++) begin
      step();
      if (bus.mem_write && !prev_wr) begin
        stores++;
        checks++; if (dbg_starve_cnt !== 4'(stores)) begin errors++; $display("FAIL starve_count_%0d: got %0d expected %0d", stores, dbg_starve_cnt, stores); end
      end
      prev_wr = bus.mem_write;
      if (bus.mem_read && !got_load) begin
        got_load = 1; bus.st_req = 0;
        checks++; if (stores != 4) begin errors++; $display("FAIL starve_stores_before_load: got %0d expected 4", stores); end
        checks++; if (dbg_starve_cnt !== 4'd0) begin errors++; $display("FAIL starve_cnt_cleared: got %0d expected 0", dbg_starve_cnt); end
      end
      if (bus.ld_resp) begin
        got_resp = 1; bus.ld_req = 0;
        checks++; if (bus.ld_rdata !== 16'h2222) begin errors++; $display("FAIL starve_load_rdata: got %h expected 2222", bus.ld_rdata); end
      end
    end
    checks++; if (!got_resp) begin errors++; $display("FAIL starve_timeout: got no ld_resp expected one within 40 cycles"); end
    bus.st_req = 0; bus.ld_req = 0;
    step();
  endtask

  task automatic test_flush_load();
    int rd = 0;
    int resp = 0;
    mem_lat = 5; mem_data = 16'hDEAD;
    bus.ld_addr = 16'h0200; bus.ld_req = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.mem_read) rd++;
      if (bus.ld_resp) resp++;
      if (i == 1) begin bus.flush = 1; bus.ld_req = 0; end
      if (i == 2) bus.flush = 0;
    end
    checks++; if (rd != 5) begin errors++; $display("FAIL flush_read_cycles: got %0d expected 5", rd); end
    checks++; if (resp != 0) begin errors++; $display("FAIL flush_ld_resp: got %0d expected 0", resp); end
`ifdef DMEM_ARB_PERF_EN
    checks++; if (perf_ld_killed !== 32'd1) begin errors++; $display("FAIL flush_perf_killed: got %0d expected 1", perf_ld_killed); end
`endif
    resp = 0;
    mem_lat = 1; mem_data = 16'hA5A5;
    bus.ld_addr = 16'h0300; bus.ld_req = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.ld_resp) begin
        resp++; bus.ld_req = 0;
        checks++; if (bus.ld_rdata !== 16'hA5A5) begin errors++; $display("FAIL flush_next_rdata: got %h expected a5a5", bus.ld_rdata); end
      end
    end
    checks++; if (resp != 1) begin errors++; $display("FAIL flush_next_resp: got %0d expected 1", resp); end
  endtask

  task automatic test_flush_idle();
    int rd = 0;
    int resp = 0;
    mem_lat = 2;
    bus.ld_addr = 16'h0040; bus.ld_req = 1; bus.flush = 1;
    step();
    checks++; if (bus.mem_read !== 1'b0 || dbg_state !== 2'd0) begin errors++; $display("FAIL flush_idle_ld_only: got rd=%0b state=%0d expected 0/0", bus.mem_read, dbg_state); end
    bus.st_addr = 16'h0030; bus.st_wdata = 16'h3333; bus.st_byte_en = 2'b10; bus.st_req = 1;
    step();
    checks++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || dbg_state !== 2'd1) begin
      errors++; $display("FAIL flush_idle_grant: got wr=%0b rd=%0b state=%0d expected 1/0/1", bus.mem_write, bus.mem_read, dbg_state);
    end
    checks++; if (bus.mem_byte_enable !== 2'b10) begin errors++; $display("FAIL flush_idle_be: got %b expected 10", bus.mem_byte_enable); end
    bus.flush = 0; bus.ld_req = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.st_resp) begin resp++; bus.st_req = 0; end
      if (bus.mem_read) rd++;
      step();
    end
    checks++; if (resp != 1) begin errors++; $display("FAIL flush_idle_st_resp: got %0d expected 1", resp); end
    checks++; if (rd != 0) begin errors++; $display("FAIL flush_idle_stale_load: got %0d read cycles expected 0", rd); end
  endtask

  task automatic test_reset_mid_store();
    int resp = 0;
    mem_lat = 10;
    bus.st_addr = 16'h0050; bus.st_wdata = 16'h5050; bus.st_byte_en = 2'b11; bus.st_req = 1;
    repeat (2) step();
    checks++; if (bus.mem_write !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: got wr=%0b expected 1", bus.mem_write); end
    reset = 1; bus.st_req = 0;
    step();
    checks++; if (bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL rst_mid_abandon: got wr=%0b rd=%0b state=%0d expected 0/0/0", bus.mem_write, bus.mem_read, dbg_state);
    end
    reset = 0;
    mem_lat = 2; mem_data = 16'h5555;
    bus.ld_addr = 16'h0060; bus.ld_req = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.ld_resp) begin
        resp++; bus.ld_req = 0;
        checks++; if (bus.ld_rdata !== 16'h5555) begin errors++; $display("FAIL rst_mid_load_rdata: got %h expected 5555", bus.ld_rdata); end
      end
    end
    checks++; if (resp != 1) begin errors++; $display("FAIL rst_mid_load_resp: got %0d expected 1", resp); end
`ifdef DMEM_ARB_PERF_EN
    checks++; if (perf_st_grants !== 32'd0 || perf_ld_grants !== 32'd1 || perf_ld_killed !== 32'd0) begin
      errors++; $display("FAIL rst_mid_perf: got %0d/%0d/%0d expected 0/1/0", perf_st_grants, perf_ld_grants, perf_ld_killed);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_single_load();
    test_starvation();
    test_flush_load();
    test_flush_idle();
    test_reset_mid_store();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between two requesters.
  - Commit-stage stores from the write-results controller: STR/STB/STI data phase.
  - Speculative loads from the load/store buffer: LDR/LDB/LDI.
- Committed stores have priority, bounded by a load-starvation limit.
- Each memory transaction is held stable until mem_resp.
- On flush, an in-flight speculative load completes on the bus, but its result is discarded.

Parameters:
- STARVE_LIMIT, 4: consecutive store grants allowed while a load waits before the load is forced ahead (1..15).
- CNT_WIDTH, 4: width of the starvation counter.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- flush  input  1  pipeline flush from commit (mispredict/trap)
- st_req  input  1  store request (commit dmem_write); held until st_resp
- st_addr  input  16  store address
- st_wdata  input  16  store data
- st_byte_en  input  2  store byte enables
- st_resp  output  1  store complete, one-cycle pulse
- ld_req  input  1  load request from ld/str buffer; held until ld_resp or flush
- ld_addr  input  16  load address
- ld_resp  output  1  load data valid, one-cycle pulse
- ld_rdata  output  16  load data, valid when ld_resp=1
- mem_read  output  1  to data memory
- mem_write  output  1  to data memory
- mem_address  output  16  to data memory
- mem_wdata  output  16  to data memory
- mem_byte_enable  output  2  to data memory
- mem_resp  input  1  memory done
- mem_rdata  input  16  memory read data

Behaviour:
- States: IDLE, STORE, LOAD.
- Reset (synchronous): state=IDLE, starve_cnt=0, kill=0.
  - All outputs read 0; mem_byte_enable=2'b11 when idle.
  - Reset mid-transaction abandons it: mem_read/mem_write are 0 in the cycle after reset is sampled.
- Latched copies:
  - mem_address/mem_wdata/mem_byte_enable are driven from registers captured at grant.
  - They are stable for the whole transaction even if requester inputs change.
- IDLE grant decision, evaluated each cycle:
  - st_req & (!ld_req | starve_cnt < STARVE_LIMIT): capture st_addr/st_wdata/st_byte_en, go to STORE.
  - If ld_req was also high, starve_cnt++ (saturating).
  - Else, ld_req & !flush: capture ld_addr and byte_en=2'b11, clear starve_cnt, go to LOAD.
  - Else stay in IDLE.
- Grant latency: the transaction starts the cycle after the request is sampled in IDLE. mem_read/mem_write are asserted from the first STORE/LOAD cycle.
- STORE:
  - mem_write=1 until mem_resp.
  - st_resp = mem_resp in the same cycle, combinational and gated by state.
  - Then return to IDLE.
  - flush has no effect in STORE: stores are architectural.
- LOAD:
  - mem_read=1 until mem_resp.
  - On mem_resp: ld_resp = mem_resp & !kill & !flush, ld_rdata = mem_rdata; return to IDLE and clear kill.
  - flush while in LOAD sets kill. The memory transaction still completes, so the port protocol is not broken, but ld_resp is suppressed.
- flush in IDLE: ld_req is ignored that cycle; a stale load is never granted. st_req is still honoured.
- Back-to-back: after mem_resp, one IDLE cycle precedes the next grant, since a requester may change its request on the resp edge.
- Simultaneous st_req & ld_req with starve_cnt==STARVE_LIMIT: the load wins, and starve_cnt resets to 0.
- mem_read and mem_write are never both 1.

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- When defined, the block adds three 32-bit output ports:
  - perf_st_grants: increments on each STORE grant.
  - perf_ld_grants: increments on each LOAD grant.
  - perf_ld_killed: increments on each suppressed ld_resp.
- Counters clear on reset and wrap modulo 2^32.
- When undefined, these ports and their counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Single store: st_req, addr=0x0040, data=0xBEEF, be=2'b01; memory responds after 3 cycles -> mem_write=1 for exactly 3 cycles with mem_address=0x0040, mem_wdata=0xBEEF, mem_byte_enable=01; st_resp pulses once.
- Single load: ld_req, addr=0x0100; mem_rdata=0x1234 -> mem_read=1 until resp; ld_resp pulses with ld_rdata=0x1234.
- Starvation, STARVE_LIMIT=4: ld_req held while st_req is re-asserted continuously -> exactly 4 store transactions, then the load is granted; starve_cnt=0 afterwards.
- Flush during load: flush pulses on cycle 2 of a 5-cycle load -> mem_read stays high until mem_resp; ld_resp=0; next IDLE accepts a new request (perf_ld_killed=1 if enabled).
- Flush in IDLE with ld_req and st_req both high -> store granted, load not granted that cycle.
- Reset asserted mid-store -> next cycle mem_write=0, state IDLE, and a following load completes normally.
